// File: rtl/maze_pkg.sv
// Shared definitions for the maze move path: direction codes, move FSM states,
// debounced-button bit positions and the direction priority encoder.
package maze_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam int BTN_TOP    = 0;
  localparam int BTN_BOTTOM = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_REL = 2'd2
  } move_state_t;

  // Up > Down > Left > Right over every button currently held.
  function automatic logic [1:0] prio_dir(input logic [3:0] db);
    if (db[BTN_TOP])         return DIR_UP;
    else if (db[BTN_BOTTOM]) return DIR_DOWN;
    else if (db[BTN_LEFT])   return DIR_LEFT;
    else                     return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: two-flop synchroniser, then a counter that only lets the
// stable level follow the sample after DEBOUNCE_CYCLES consecutive differing cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic sync_o,
  output logic level_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= raw_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_o  = sync_q;
  assign level_o = level_q;

endmodule

// File: rtl/btn_move_ctrl.sv
// Turns four bouncy push-buttons into single-shot 2-bit move commands over a
// valid/ready handshake: one move per press-and-release-all cycle.
module btn_move_ctrl
  import maze_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnTop,
  input  logic       btnBottom,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [3:0] btn_db,
  output logic       busy
);

  logic [3:0]  raw;
  logic [3:0]  sample;
  logic [3:0]  db;
  logic [3:0]  prev_q;
  logic [1:0]  settle_q;
  logic        arm_q;
  logic        press;
  move_state_t state_q;
  move_state_t state_d;
  logic [1:0]  dir_q;
  logic [1:0]  dir_d;
  logic        valid_q;
  logic        valid_d;

  always_comb begin
    raw             = '0;
    raw[BTN_TOP]    = btnTop;
    raw[BTN_BOTTOM] = btnBottom;
    raw[BTN_LEFT]   = btnLeft;
    raw[BTN_RIGHT]  = btnRight;
  end

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i  (clk),
      .rst_i  (reset),
      .raw_i  (raw[i]),
      .sync_o (sample[i]),
      .level_o(db[i])
    );
  end

  // Buttons held through reset must not count as a press once the debouncers
  // catch up, so moves stay disarmed until all synchronised inputs read low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q   <= '0;
      settle_q <= '0;
      arm_q    <= 1'b0;
    end else begin
      prev_q   <= db;
      settle_q <= {settle_q[0], 1'b1};
      if (settle_q[1] && (db == '0) && (sample == '0)) begin
        arm_q <= 1'b1;
      end
    end
  end

  assign press = arm_q && ((db & ~prev_q) != '0);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          dir_d   = prio_dir(db);
          valid_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (valid_q && move_ready) begin
          valid_d = 1'b0;
          state_d = (db == '0) ? ST_IDLE : ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (db == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
    end
  end

  assign move_valid = valid_q;
  assign move_dir   = dir_q;
  assign btn_db     = db;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_btn_move_ctrl.sv
// Directed bench for btn_move_ctrl with DEBOUNCE_CYCLES=4; expected moves are
// queued as presses are driven and popped when the DUT hands a move over.
module tb_btn_move_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btnTop, btnBottom, btnLeft, btnRight;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [3:0] btn_db;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  btn_move_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .btnTop    (btnTop),
    .btnBottom (btnBottom),
    .btnLeft   (btnLeft),
    .btnRight  (btnRight),
    .move_ready(move_ready),
    .move_valid(move_valid),
    .move_dir  (move_dir),
    .btn_db    (btn_db),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Order {Right, Left, Bottom, Top}.
  task automatic set_btn(input logic [3:0] b);
    {btnRight, btnLeft, btnBottom, btnTop} = b;
  endtask

  task automatic release_all();
    set_btn(4'b0000);
    tick(12);
    chk("release_db", {28'd0, btn_db}, 32'h0);
    chk("release_busy", {31'd0, busy}, 32'h0);
  endtask

  // Scoreboard: every accepted handshake must match the oldest queued move.
  always @(negedge clk) begin
    if (reset === 1'b0 && move_valid === 1'b1 && move_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_move observed_dir=%0b expected=none", move_dir);
      end
      if (exp_q.size() > 0) begin
        chk("sb_move_dir", {30'd0, move_dir}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    // Reset with every button held: outputs clear without a clock edge.
    reset = 1'b1;
    move_ready = 1'b1;
    set_btn(4'b1111);
    #1;
    chk("rst_valid", {31'd0, move_valid}, 32'h0);
    chk("rst_dir", {30'd0, move_dir}, 32'h0);
    chk("rst_db", {28'd0, btn_db}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    tick(3);
    chk("rst_hold_db", {28'd0, btn_db}, 32'h0);
    reset = 1'b0;
    tick(20);
    chk("held_db", {28'd0, btn_db}, 32'hf);
    chk("held_valid", {31'd0, move_valid}, 32'h0);
    chk("held_busy", {31'd0, busy}, 32'h0);
    release_all();

    // Clean Left press, exact latencies.
    set_btn(4'b0100);
    exp_q.push_back(2'b01);
    tick(5);
    chk("left_db_early", {28'd0, btn_db}, 32'h0);
    tick(1);
    chk("left_db", {28'd0, btn_db}, 32'h4);
    chk("left_valid_early", {31'd0, move_valid}, 32'h0);
    tick(1);
    chk("left_valid", {31'd0, move_valid}, 32'h1);
    chk("left_dir", {30'd0, move_dir}, 32'h1);
    chk("left_busy", {31'd0, busy}, 32'h1);
    tick(1);
    chk("left_valid_drop", {31'd0, move_valid}, 32'h0);
    chk("left_busy_held", {31'd0, busy}, 32'h1);
    tick(12);
    set_btn(4'b0000);
    tick(5);
    chk("left_rel_db_early", {28'd0, btn_db}, 32'h4);
    chk("left_rel_busy_early", {31'd0, busy}, 32'h1);
    tick(1);
    chk("left_rel_db", {28'd0, btn_db}, 32'h0);
    chk("left_rel_busy_last", {31'd0, busy}, 32'h1);
    tick(1);
    chk("left_rel_busy", {31'd0, busy}, 32'h0);
    chk("left_sb_empty", exp_q.size(), 32'h0);
    tick(4);

    // Bouncing Right: toggles every 2 cycles, then settles high.
    for (int i = 0; i < 6; i++) begin
      set_btn((i % 2 == 0) ? 4'b1000 : 4'b0000);
      tick(2);
    end
    chk("bounce_db", {28'd0, btn_db}, 32'h0);
    chk("bounce_busy", {31'd0, busy}, 32'h0);
    set_btn(4'b1000);
    exp_q.push_back(2'b10);
    tick(7);
    chk("bounce_valid", {31'd0, move_valid}, 32'h1);
    chk("bounce_dir", {30'd0, move_dir}, 32'h2);
    tick(8);
    chk("bounce_sb_empty", exp_q.size(), 32'h0);
    release_all();

    // Backpressure on a Bottom press.
    move_ready = 1'b0;
    set_btn(4'b0010);
    exp_q.push_back(2'b11);
    tick(7);
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid_hold", {31'd0, move_valid}, 32'h1);
      chk("bp_dir_hold", {30'd0, move_dir}, 32'h3);
      tick(1);
    end
    move_ready = 1'b1;
    chk("bp_valid_at_accept", {31'd0, move_valid}, 32'h1);
    tick(1);
    chk("bp_valid_drop", {31'd0, move_valid}, 32'h0);
    chk("bp_sb_empty", exp_q.size(), 32'h0);
    release_all();

    // Simultaneous presses and priority.
    set_btn(4'b0011);
    exp_q.push_back(2'b00);
    tick(7);
    chk("tb_valid", {31'd0, move_valid}, 32'h1);
    chk("tb_dir", {30'd0, move_dir}, 32'h0);
    release_all();
    set_btn(4'b1100);
    exp_q.push_back(2'b01);
    tick(7);
    chk("lr_dir", {30'd0, move_dir}, 32'h1);
    set_btn(4'b1101);
    tick(12);
    chk("second_press_db", {28'd0, btn_db}, 32'hd);
    chk("second_press_sb_empty", exp_q.size(), 32'h0);
    release_all();
    set_btn(4'b1110);
    exp_q.push_back(2'b11);
    tick(7);
    chk("blr_dir", {30'd0, move_dir}, 32'h3);
    release_all();

    // Reset while a move is pending.
    move_ready = 1'b0;
    set_btn(4'b0001);
    tick(7);
    chk("mid_valid_before", {31'd0, move_valid}, 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, move_valid}, 32'h0);
    chk("mid_rst_busy", {31'd0, busy}, 32'h0);
    chk("mid_rst_db", {28'd0, btn_db}, 32'h0);
    tick(2);
    reset = 1'b0;
    move_ready = 1'b1;
    tick(20);
    chk("mid_held_db", {28'd0, btn_db}, 32'h1);
    chk("mid_held_valid", {31'd0, move_valid}, 32'h0);
    chk("mid_held_busy", {31'd0, busy}, 32'h0);
    release_all();
    set_btn(4'b0001);
    exp_q.push_back(2'b00);
    tick(7);
    chk("repress_valid", {31'd0, move_valid}, 32'h1);
    chk("repress_dir", {30'd0, move_dir}, 32'h0);
    tick(1);
    release_all();

    chk("final_sb_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
